// File: rtl/trs80_pkg.sv
// Shared types and constants for the TRS-80 bus controller slice.
package trs80_pkg;

   // Decoded target of the current CPU memory cycle
   typedef enum logic [2:0] {
      REG_NONE = 3'd0,
      REG_ROM  = 3'd1,
      REG_RAM  = 3'd2,
      REG_VRAM = 3'd3,
      REG_KBD  = 3'd4
   } region_t;

   // Bus controller sequencing states
   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DL   = 2'd2
   } bus_state_t;

   // Fixed 1 KiB pages for keyboard matrix and video RAM
   localparam logic [15:0] KBD_BASE  = 16'h3800;
   localparam logic [15:0] VRAM_BASE = 16'h3C00;
   localparam logic [5:0]  KBD_PAGE  = KBD_BASE[15:10];
   localparam logic [5:0]  VRAM_PAGE = VRAM_BASE[15:10];

   // Half-open window test; 17-bit bounds so a window may end at 0x10000
   function automatic logic in_window(input logic [15:0] addr,
                                      input logic [16:0] lo,
                                      input logic [16:0] hi);
      return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
   endfunction

endpackage

// File: rtl/trs80_wait_gen.sv
// Per-access wait-state generator: loads the region's wait count on the
// first cycle of a memory access and holds WAIT_n low for that many cycles.
module trs80_wait_gen
   import trs80_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       mreq_n,
   input  logic       abort,
   input  logic [2:0] ws,
   output logic       wait_n
);

   logic       mreq_d_r;
   logic [2:0] cnt_r;
   logic [2:0] cnt_nxt_s;
   logic       start_s;
   logic       wait_n_r;

   // A falling MREQ_n relative to last cycle marks the first cycle of an access
   assign start_s = mreq_d_r & ~mreq_n;

   // Next wait count: abort/bus release clear it, start loads it, then count down
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (abort || mreq_n) begin
         cnt_nxt_s = 3'd0;
      end else if (start_s) begin
         cnt_nxt_s = ws;
      end else if (cnt_r != 3'd0) begin
         cnt_nxt_s = cnt_r - 3'd1;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter, MREQ_n history and registered WAIT_n
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mreq_d_r <= 1'b1;
         cnt_r    <= 3'd0;
         wait_n_r <= 1'b1;
      end else begin
         mreq_d_r <= mreq_n;
         cnt_r    <= cnt_nxt_s;
         wait_n_r <= (cnt_nxt_s == 3'd0);
      end
   end

   assign wait_n = wait_n_r;

endmodule

// File: rtl/trs80_bus_ctrl.sv
// TRS-80 bus controller: CPU reset sequencing, download arbitration,
// address decode, read-data mux and per-region wait-state insertion.
module trs80_bus_ctrl
   import trs80_pkg::*;
#(
   parameter int          RESET_HOLD = 255,
   parameter int          ROM_AW     = 14,
   parameter int          RAM_AW     = 14,
   parameter logic [15:0] RAM_BASE   = 16'h4000,
   parameter int          WS_ROM     = 1,
   parameter int          WS_RAM     = 0,
   parameter int          DL_AW      = 25
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pll_locked,
   input  logic              sys_reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [DL_AW-1:0]  dl_addr,
   input  logic [7:0]        dl_data,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_mreq_n,
   input  logic              cpu_rd_n,
   input  logic              cpu_wr_n,
   input  logic [7:0]        rom_dout,
   input  logic [7:0]        ram_dout,
   input  logic [7:0]        vram_dout,
   input  logic [7:0]        kbd_dout,
   output logic              cpu_reset_n,
   output logic              cpu_wait_n,
   output logic [7:0]        cpu_din,
   output logic              rom_cs_n,
   output logic              ram_cs_n,
   output logic              vram_cs_n,
   output logic              kbd_cs_n,
   output logic              mem_we,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_we,
   output logic [7:0]        rom_wdata,
   output logic              rom_loaded
);

   // ROM window stops where the keyboard page begins
   localparam int          ROM_SIZE  = 32'sd1 << ROM_AW;
   localparam int          ROM_LIMIT = (ROM_SIZE < 32'sd14336) ? ROM_SIZE : 32'sd14336;
   localparam logic [16:0] ROM_TOP   = 17'(ROM_LIMIT);
   localparam logic [16:0] RAM_LO    = 17'(RAM_BASE);
   localparam logic [16:0] RAM_HI    = 17'(int'(RAM_BASE) + (32'sd1 << RAM_AW));
   localparam logic [2:0]  WS_ROM_3  = 3'(WS_ROM);
   localparam logic [2:0]  WS_RAM_3  = 3'(WS_RAM);

   localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   bus_state_t        state_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic              cpu_reset_n_r;
   logic              rom_loaded_r;
   logic              dl_active_d_r;
   logic              dl_fall_s;
   logic              abort_s;

   region_t           region_s;
   logic [7:0]        sel_dout_s;
   logic [2:0]        ws_s;
   logic              rom_cs_n_s;
   logic              ram_cs_n_s;
   logic              vram_cs_n_s;
   logic              kbd_cs_n_s;
   logic              dl_in_range_s;

   assign dl_fall_s = dl_active_d_r & ~dl_active;

   // Reset sequencing FSM: DL beats HOLD causes, HOLD counts out before RUN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_HOLD;
         hold_cnt_r    <= '0;
         cpu_reset_n_r <= 1'b0;
         rom_loaded_r  <= 1'b0;
         dl_active_d_r <= 1'b0;
      end else begin
         dl_active_d_r <= dl_active;
         if ((state_r == ST_DL) && dl_fall_s) begin
            rom_loaded_r <= 1'b1;
         end else begin
            rom_loaded_r <= rom_loaded_r;
         end

         if (dl_active) begin
            state_r       <= ST_DL;
            hold_cnt_r    <= '0;
            cpu_reset_n_r <= 1'b0;
         end else if (!pll_locked || sys_reset) begin
            state_r       <= ST_HOLD;
            hold_cnt_r    <= '0;
            cpu_reset_n_r <= 1'b0;
         end else begin
            case (state_r)
               ST_HOLD: begin
                  if (hold_cnt_r == HOLD_LAST) begin
                     state_r       <= ST_RUN;
                     hold_cnt_r    <= hold_cnt_r;
                     cpu_reset_n_r <= 1'b1;
                  end else begin
                     state_r       <= ST_HOLD;
                     hold_cnt_r    <= hold_cnt_r + HOLD_W'(1);
                     cpu_reset_n_r <= 1'b0;
                  end
               end
               ST_RUN: begin
                  state_r       <= ST_RUN;
                  hold_cnt_r    <= hold_cnt_r;
                  cpu_reset_n_r <= 1'b1;
               end
               ST_DL: begin
                  // dl_active is low here, so the download has just ended
                  state_r       <= ST_HOLD;
                  hold_cnt_r    <= '0;
                  cpu_reset_n_r <= 1'b0;
               end
               default: begin
                  state_r       <= ST_HOLD;
                  hold_cnt_r    <= '0;
                  cpu_reset_n_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Address decode, only for CPU memory cycles while the CPU is running
   always_comb begin
      region_s = REG_NONE;
      if ((state_r == ST_RUN) && !cpu_mreq_n) begin
         if (in_window(cpu_addr, 17'd0, ROM_TOP)) begin
            region_s = REG_ROM;
         end else if (cpu_addr[15:10] == KBD_PAGE) begin
            region_s = REG_KBD;
         end else if (cpu_addr[15:10] == VRAM_PAGE) begin
            region_s = REG_VRAM;
         end else if (in_window(cpu_addr, RAM_LO, RAM_HI)) begin
            region_s = REG_RAM;
         end else begin
            region_s = REG_NONE;
         end
      end else begin
         region_s = REG_NONE;
      end
   end

   // Per-region chip select, read data and wait-state count
   always_comb begin
      sel_dout_s  = 8'hFF;
      ws_s        = 3'd0;
      rom_cs_n_s  = 1'b1;
      ram_cs_n_s  = 1'b1;
      vram_cs_n_s = 1'b1;
      kbd_cs_n_s  = 1'b1;
      case (region_s)
         REG_ROM: begin
            sel_dout_s = rom_dout;
            ws_s       = WS_ROM_3;
            rom_cs_n_s = 1'b0;
         end
         REG_RAM: begin
            sel_dout_s = ram_dout;
            ws_s       = WS_RAM_3;
            ram_cs_n_s = 1'b0;
         end
         REG_VRAM: begin
            sel_dout_s  = vram_dout;
            vram_cs_n_s = 1'b0;
         end
         REG_KBD: begin
            sel_dout_s = kbd_dout;
            kbd_cs_n_s = 1'b0;
         end
         default: begin
            sel_dout_s = 8'hFF;
         end
      endcase
   end

   // Read-data bus floats high whenever the CPU is not reading
   always_comb begin
      if (!cpu_rd_n) begin
         cpu_din = sel_dout_s;
      end else begin
         cpu_din = 8'hFF;
      end
   end

   assign rom_cs_n  = rom_cs_n_s;
   assign ram_cs_n  = ram_cs_n_s;
   assign vram_cs_n = vram_cs_n_s;
   assign kbd_cs_n  = kbd_cs_n_s;
   assign mem_we    = ~cpu_wr_n & ~cpu_mreq_n &
                      ((region_s == REG_RAM) || (region_s == REG_VRAM));

   // Download writes beyond the ROM image are dropped
   assign dl_in_range_s = ((dl_addr >> ROM_AW) == '0);

   // ROM port is owned by the downloader while in DL, otherwise by the CPU
   always_comb begin
      if (state_r == ST_DL) begin
         rom_addr = dl_addr[ROM_AW-1:0];
         rom_we   = dl_wr & dl_in_range_s;
      end else begin
         rom_addr = cpu_addr[ROM_AW-1:0];
         rom_we   = 1'b0;
      end
   end

   assign rom_wdata = dl_data;

   // Any cause that takes the CPU out of RUN kills a pending wait at the same edge
   assign abort_s = (state_r != ST_RUN) | dl_active | ~pll_locked | sys_reset;

   trs80_wait_gen u_wait_gen (
      .clock   (clock),
      .reset_n (reset_n),
      .mreq_n  (cpu_mreq_n),
      .abort   (abort_s),
      .ws      (ws_s),
      .wait_n  (cpu_wait_n)
   );

   assign cpu_reset_n = cpu_reset_n_r;
   assign rom_loaded  = rom_loaded_r;

endmodule

// File: tb/tb_trs80_bus_ctrl.sv
// Directed bench for trs80_bus_ctrl with hand-computed expectations.
module tb_trs80_bus_ctrl;

   localparam int RH = 255;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        pll_locked;
   logic        sys_reset;
   logic        dl_active;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [15:0] cpu_addr;
   logic        cpu_mreq_n;
   logic        cpu_rd_n;
   logic        cpu_wr_n;
   logic [7:0]  rom_dout;
   logic [7:0]  ram_dout;
   logic [7:0]  vram_dout;
   logic [7:0]  kbd_dout;
   logic        cpu_reset_n;
   logic        cpu_wait_n;
   logic [7:0]  cpu_din;
   logic        rom_cs_n;
   logic        ram_cs_n;
   logic        vram_cs_n;
   logic        kbd_cs_n;
   logic        mem_we;
   logic [13:0] rom_addr;
   logic        rom_we;
   logic [7:0]  rom_wdata;
   logic        rom_loaded;
   logic [3:0]  cs_s;

   int vec_cnt = 0;
   int err_cnt = 0;
   int n_hold;

   assign cs_s = {rom_cs_n, ram_cs_n, vram_cs_n, kbd_cs_n};

   always #5 clock = ~clock;

   trs80_bus_ctrl #(
      .RESET_HOLD (RH),
      .ROM_AW     (14),
      .RAM_AW     (14),
      .RAM_BASE   (16'h4000),
      .WS_ROM     (1),
      .WS_RAM     (0),
      .DL_AW      (25)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .sys_reset   (sys_reset),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .cpu_addr    (cpu_addr),
      .cpu_mreq_n  (cpu_mreq_n),
      .cpu_rd_n    (cpu_rd_n),
      .cpu_wr_n    (cpu_wr_n),
      .rom_dout    (rom_dout),
      .ram_dout    (ram_dout),
      .vram_dout   (vram_dout),
      .kbd_dout    (kbd_dout),
      .cpu_reset_n (cpu_reset_n),
      .cpu_wait_n  (cpu_wait_n),
      .cpu_din     (cpu_din),
      .rom_cs_n    (rom_cs_n),
      .ram_cs_n    (ram_cs_n),
      .vram_cs_n   (vram_cs_n),
      .kbd_cs_n    (kbd_cs_n),
      .mem_we      (mem_we),
      .rom_addr    (rom_addr),
      .rom_we      (rom_we),
      .rom_wdata   (rom_wdata),
      .rom_loaded  (rom_loaded)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Edges until cpu_reset_n is seen high; -1 if the bound expires
   task automatic count_hold(output int n);
      n = -1;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (cpu_reset_n === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic access(input logic [15:0] a, input logic wr);
      cpu_addr   = a;
      cpu_mreq_n = 1'b0;
      cpu_rd_n   = wr;
      cpu_wr_n   = ~wr;
      #1;
   endtask

   task automatic release_bus();
      cpu_mreq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
   endtask

   task automatic idle();
      release_bus();
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      pll_locked = 1'b1;
      sys_reset  = 1'b0;
      dl_active  = 1'b0;
      dl_wr      = 1'b0;
      dl_addr    = 25'd0;
      dl_data    = 8'h00;
      cpu_addr   = 16'h0000;
      release_bus();
      rom_dout   = 8'h5A;
      ram_dout   = 8'h66;
      vram_dout  = 8'h77;
      kbd_dout   = 8'h88;
      repeat (3) tick();

      // reset state
      check_val("rst_cpu_reset_n", cpu_reset_n, 1'b0);
      check_val("rst_wait_n", cpu_wait_n, 1'b1);
      check_val("rst_cs_n", cs_s, 4'hF);
      check_val("rst_mem_we", mem_we, 1'b0);
      check_val("rst_rom_we", rom_we, 1'b0);
      check_val("rst_rom_loaded", rom_loaded, 1'b0);

      // hold after reset release
      reset_n = 1'b1;
      count_hold(n_hold);
      check_val("hold_after_reset", n_hold, RH);

      // ROM read with one wait state
      access(16'h0123, 1'b0);
      check_val("rom_rd_cs", cs_s, 4'b0111);
      check_val("rom_rd_din", cpu_din, 8'h5A);
      check_val("rom_rd_wait_pre", cpu_wait_n, 1'b1);
      tick();
      check_val("rom_rd_wait_low", cpu_wait_n, 1'b0);
      tick();
      check_val("rom_rd_wait_rel", cpu_wait_n, 1'b1);
      idle();

      // writes and decode boundaries
      access(16'h3C10, 1'b1);
      check_val("vram_wr_cs", cs_s, 4'b1101);
      check_val("vram_wr_we", mem_we, 1'b1);
      tick();
      check_val("vram_no_wait", cpu_wait_n, 1'b1);
      idle();
      access(16'h0010, 1'b1);
      check_val("rom_wr_we", mem_we, 1'b0);
      check_val("rom_wr_cs", cs_s, 4'b0111);
      idle();
      access(16'hE000, 1'b0);
      check_val("unmap_din", cpu_din, 8'hFF);
      check_val("unmap_cs", cs_s, 4'hF);
      idle();
      access(16'h37FF, 1'b0);
      check_val("rom_top_cs", cs_s, 4'b0111);
      idle();
      access(16'h3800, 1'b0);
      check_val("kbd_cs", cs_s, 4'b1110);
      check_val("kbd_din", cpu_din, 8'h88);
      idle();
      access(16'h3FFF, 1'b0);
      check_val("vram_top_din", cpu_din, 8'h77);
      idle();
      access(16'h4000, 1'b1);
      check_val("ram_wr_cs", cs_s, 4'b1011);
      check_val("ram_wr_we", mem_we, 1'b1);
      idle();
      access(16'h7FFF, 1'b0);
      check_val("ram_top_din", cpu_din, 8'h66);
      idle();
      access(16'h8000, 1'b0);
      check_val("ram_end_cs", cs_s, 4'hF);
      idle();

      // sys_reset in the first cycle of a ROM access
      access(16'h0100, 1'b0);
      sys_reset = 1'b1;
      tick();
      check_val("abort_wait_n", cpu_wait_n, 1'b1);
      check_val("abort_reset_n", cpu_reset_n, 1'b0);
      check_val("abort_cs", cs_s, 4'hF);
      sys_reset = 1'b0;
      release_bus();
      count_hold(n_hold);
      check_val("hold_after_sysrst", n_hold, RH);

      // download
      dl_active = 1'b1;
      tick();
      check_val("dl_reset_n", cpu_reset_n, 1'b0);
      dl_addr = 25'h0000005;
      dl_data = 8'hC3;
      dl_wr   = 1'b1;
      access(16'h0000, 1'b0);
      check_val("dl_rom_we", rom_we, 1'b1);
      check_val("dl_rom_addr", rom_addr, 14'h0005);
      check_val("dl_rom_wdata", rom_wdata, 8'hC3);
      check_val("dl_cpu_cs", cs_s, 4'hF);
      tick();
      dl_addr = 25'h0004000;
      #1;
      check_val("dl_oor_we", rom_we, 1'b0);
      dl_addr = 25'h0003FFF;
      #1;
      check_val("dl_last_we", rom_we, 1'b1);
      check_val("dl_last_addr", rom_addr, 14'h3FFF);
      tick();
      dl_wr = 1'b0;
      release_bus();
      check_val("dl_not_loaded", rom_loaded, 1'b0);
      dl_active = 1'b0;
      tick();
      check_val("dl_loaded", rom_loaded, 1'b1);
      check_val("dl_end_reset_n", cpu_reset_n, 1'b0);
      count_hold(n_hold);
      check_val("hold_after_dl", n_hold, RH);

      // download and sys_reset together
      dl_active = 1'b1;
      sys_reset = 1'b1;
      tick();
      dl_wr   = 1'b1;
      dl_addr = 25'h0000007;
      #1;
      check_val("both_rom_we", rom_we, 1'b1);
      check_val("both_reset_n", cpu_reset_n, 1'b0);
      dl_wr     = 1'b0;
      dl_active = 1'b0;
      sys_reset = 1'b0;
      tick();
      check_val("both_end_reset_n", cpu_reset_n, 1'b0);
      count_hold(n_hold);
      check_val("hold_after_both", n_hold, RH);
      check_val("both_loaded", rom_loaded, 1'b1);

      // PLL loss holds the CPU in reset indefinitely
      pll_locked = 1'b0;
      tick();
      check_val("pll_reset_n", cpu_reset_n, 1'b0);
      repeat (300) tick();
      check_val("pll_long_reset_n", cpu_reset_n, 1'b0);
      pll_locked = 1'b1;
      count_hold(n_hold);
      check_val("hold_after_pll", n_hold, RH);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
